// File: rtl/hazard_scoreboard_pkg.sv
// Opcode encodings and opcode-classification helpers shared by the hazard
// scoreboard and its bench.
package hazard_scoreboard_pkg;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  typedef enum logic [1:0] {OPC_NONE, OPC_ALU, OPC_LOAD, OPC_MUL} op_class_e;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    case (opcode)
      OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH,
      OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    case (opcode)
      OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [6:0] opcode);
    case (opcode)
      OPCODE_OP, OPCODE_OPIMM, OPCODE_LOAD, OPCODE_LUI,
      OPCODE_AUIPC, OPCODE_JAL, OPCODE_JALR: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  // The M-extension flag only matters for register-register ops.
  function automatic op_class_e op_class(input logic [6:0] opcode, input logic is_mul);
    case (opcode)
      OPCODE_OP:    return is_mul ? OPC_MUL : OPC_ALU;
      OPCODE_LOAD:  return OPC_LOAD;
      OPCODE_OPIMM, OPCODE_LUI, OPCODE_AUIPC,
      OPCODE_JAL, OPCODE_JALR: return OPC_ALU;
      default:      return OPC_NONE;
    endcase
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage view of the hazard scoreboard: decoded operands in, stall and
// per-register busy flags out.
interface hazard_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
);
  logic                id_valid_ip;
  logic [6:0]          id_instr_opcode_ip;
  logic                id_is_mul_ip;
  logic [ADDR_W-1:0]   id_src1_addr_ip;
  logic [ADDR_W-1:0]   id_src2_addr_ip;
  logic [ADDR_W-1:0]   id_dest_addr_ip;
  logic                flush_ip;
  logic                stall_op;
  logic [NUM_REGS-1:0] busy_vec_op;

  modport master (
    output id_valid_ip, id_instr_opcode_ip, id_is_mul_ip,
           id_src1_addr_ip, id_src2_addr_ip, id_dest_addr_ip, flush_ip,
    input  stall_op, busy_vec_op
  );

  modport slave (
    input  id_valid_ip, id_instr_opcode_ip, id_is_mul_ip,
           id_src1_addr_ip, id_src2_addr_ip, id_dest_addr_ip, flush_ip,
    output stall_op, busy_vec_op
  );
endinterface

// File: rtl/hazard_scoreboard_lat_counter.sv
// Per-register countdown of cycles until an in-flight result is consumable.
// Priority: reset, clear (flush), load (issue), then decrement.
module hazard_lat_counter #(
  parameter int LAT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [LAT_W-1:0] load_val,
  output logic [LAT_W-1:0] cnt,
  output logic             nonzero
);

  always_ff @(posedge clk) begin
    if (!reset)          cnt <= '0;
    else if (clear)      cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign nonzero = |cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage RAW/WAW hazard scoreboard with per-register latency countdowns.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating stall counters.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int ADDR_W     = 5,
  parameter int FORWARD_EN = 1,
  parameter int LOAD_LAT   = 1,
  parameter int MUL_LAT    = 3,
  parameter int WB_DIST    = 3
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int CNT_W      = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  hazard_scoreboard_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycle_cnt_op,
  output logic [CNT_W-1:0] raw_stall_cnt_op,
  output logic [CNT_W-1:0] waw_stall_cnt_op
`endif
);

  // Without forwarding every consumer also waits for writeback.
  localparam int EXTRA_LAT = (FORWARD_EN != 0) ? 0 : WB_DIST;
  localparam int ALU_L     = EXTRA_LAT;
  localparam int LOAD_L    = LOAD_LAT + EXTRA_LAT;
  localparam int MUL_L     = MUL_LAT + EXTRA_LAT;
  localparam int MAX_LAT   = max_int(ALU_L, max_int(LOAD_L, MUL_L));
  localparam int LAT_W     = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;

  op_class_e                        op_cls;
  logic                             use_rs1;
  logic                             use_rs2;
  logic                             wr_rd;
  logic [LAT_W-1:0]                 issue_lat;
  logic                             raw;
  logic                             waw;
  logic                             stall;
  logic                             issue;
  logic [NUM_REGS-1:1]              load_vec;
  logic [NUM_REGS-1:0]              busy_vec;
  logic [NUM_REGS-1:1][LAT_W-1:0]   cnt;

  always_comb begin
    op_cls  = op_class(bus.id_instr_opcode_ip, bus.id_is_mul_ip);
    use_rs1 = uses_rs1(bus.id_instr_opcode_ip);
    use_rs2 = uses_rs2(bus.id_instr_opcode_ip);
    wr_rd   = writes_rd(bus.id_instr_opcode_ip);
    case (op_cls)
      OPC_MUL:  issue_lat = LAT_W'(MUL_L);
      OPC_LOAD: issue_lat = LAT_W'(LOAD_L);
      OPC_ALU:  issue_lat = LAT_W'(ALU_L);
      default:  issue_lat = '0;
    endcase
  end

  // x0 is never tracked, and addresses beyond NUM_REGS-1 never match.
  always_comb begin
    raw = 1'b0;
    waw = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (use_rs1 && bus.id_src1_addr_ip == ADDR_W'(r) && busy_vec[r]) raw = 1'b1;
      if (use_rs2 && bus.id_src2_addr_ip == ADDR_W'(r) && busy_vec[r]) raw = 1'b1;
      if (wr_rd && bus.id_dest_addr_ip == ADDR_W'(r) && cnt[r] > issue_lat) waw = 1'b1;
    end
  end

  assign stall = bus.id_valid_ip & ~bus.flush_ip & reset & (raw | waw);
  assign issue = bus.id_valid_ip & ~stall & ~bus.flush_ip & wr_rd &
                 (bus.id_dest_addr_ip != '0);

  always_comb begin
    load_vec = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      load_vec[r] = issue && (bus.id_dest_addr_ip == ADDR_W'(r));
    end
  end

  assign busy_vec[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    hazard_lat_counter #(.LAT_W(LAT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .clear    (bus.flush_ip),
      .load     (load_vec[r]),
      .load_val (issue_lat),
      .cnt      (cnt[r]),
      .nonzero  (busy_vec[r])
    );
  end

  assign bus.stall_op    = stall;
  assign bus.busy_vec_op = busy_vec;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // RAW wins attribution when both causes are present in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycle_cnt_op <= '0;
      raw_stall_cnt_op   <= '0;
      waw_stall_cnt_op   <= '0;
    end else if (stall) begin
      if (stall_cycle_cnt_op != CNT_MAX) stall_cycle_cnt_op <= stall_cycle_cnt_op + CNT_W'(1);
      if (raw) begin
        if (raw_stall_cnt_op != CNT_MAX) raw_stall_cnt_op <= raw_stall_cnt_op + CNT_W'(1);
      end else if (waw_stall_cnt_op != CNT_MAX) begin
        waw_stall_cnt_op <= waw_stall_cnt_op + CNT_W'(1);
      end
    end
  end
`else
  // Performance counters are not built; hazard behaviour is unchanged.
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  typedef struct {
    bit          nf;
    int          id;
    bit          stall;
    logic [31:0] busy;
    bit          chk_perf;
    logic [31:0] p_stall;
    logic [31:0] p_raw;
    logic [31:0] p_waw;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_id  = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  hazard_scoreboard_if #(.NUM_REGS(32), .ADDR_W(5)) bus ();
  hazard_scoreboard_if #(.NUM_REGS(32), .ADDR_W(5)) bus_nf ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] p_stall, p_raw, p_waw;
  logic [31:0] nf_p_stall, nf_p_raw, nf_p_waw;
`endif

  hazard_scoreboard #(.FORWARD_EN(1)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycle_cnt_op (p_stall),
    .raw_stall_cnt_op   (p_raw),
    .waw_stall_cnt_op   (p_waw)
`endif
  );

  hazard_scoreboard #(.FORWARD_EN(0)) dut_nf (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus_nf)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycle_cnt_op (nf_p_stall),
    .raw_stall_cnt_op   (nf_p_raw),
    .waw_stall_cnt_op   (nf_p_waw)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] bit_of(input int r);
    return 32'h1 << r;
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s step=%0d got=%h expected=%h", nm, id, got, exp);
    end
  endtask

  task automatic idle_all();
    bus.id_valid_ip = 1'b0;         bus_nf.id_valid_ip = 1'b0;
    bus.id_instr_opcode_ip = 7'h0;  bus_nf.id_instr_opcode_ip = 7'h0;
    bus.id_is_mul_ip = 1'b0;        bus_nf.id_is_mul_ip = 1'b0;
    bus.id_src1_addr_ip = 5'd0;     bus_nf.id_src1_addr_ip = 5'd0;
    bus.id_src2_addr_ip = 5'd0;     bus_nf.id_src2_addr_ip = 5'd0;
    bus.id_dest_addr_ip = 5'd0;     bus_nf.id_dest_addr_ip = 5'd0;
    bus.flush_ip = 1'b0;            bus_nf.flush_ip = 1'b0;
  endtask

  task automatic step(input bit nf, input bit v, input logic [6:0] op, input bit mul,
                      input int rs1, input int rs2, input int rd, input bit fl,
                      input bit rn, input bit es, input logic [31:0] eb,
                      input bit cp = 1'b0, input logic [31:0] ps = '0,
                      input logic [31:0] pr = '0, input logic [31:0] pw = '0);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rn;
    idle_all();
    if (nf) begin
      bus_nf.id_valid_ip = v;   bus_nf.id_instr_opcode_ip = op; bus_nf.id_is_mul_ip = mul;
      bus_nf.id_src1_addr_ip = 5'(rs1); bus_nf.id_src2_addr_ip = 5'(rs2);
      bus_nf.id_dest_addr_ip = 5'(rd);  bus_nf.flush_ip = fl;
    end else begin
      bus.id_valid_ip = v;   bus.id_instr_opcode_ip = op; bus.id_is_mul_ip = mul;
      bus.id_src1_addr_ip = 5'(rs1); bus.id_src2_addr_ip = 5'(rs2);
      bus.id_dest_addr_ip = 5'(rd);  bus.flush_ip = fl;
    end
    e.nf = nf; e.id = step_id; e.stall = es; e.busy = eb;
    e.chk_perf = cp; e.p_stall = ps; e.p_raw = pr; e.p_waw = pw;
    exp_q.push_back(e);
    step_id++;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      if (mon_e.nf) begin
        chk("nf_stall", mon_e.id, 32'(bus_nf.stall_op), 32'(mon_e.stall));
        chk("nf_busy", mon_e.id, bus_nf.busy_vec_op, mon_e.busy);
      end else begin
        chk("stall", mon_e.id, 32'(bus.stall_op), 32'(mon_e.stall));
        chk("busy", mon_e.id, bus.busy_vec_op, mon_e.busy);
`ifdef HAZARD_PERF_CNT_EN
        if (mon_e.chk_perf) begin
          chk("perf_stall", mon_e.id, p_stall, mon_e.p_stall);
          chk("perf_raw", mon_e.id, p_raw, mon_e.p_raw);
          chk("perf_waw", mon_e.id, p_waw, mon_e.p_waw);
        end
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle_all();
    // reset state
    step(0, 0, 7'h0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
    // LOAD x5 then dependent ADD: one stall cycle, then back-to-back ALU
    step(0, 1, OPCODE_LOAD, 0, 1, 0, 5, 0, 1, 0, 32'h0);
    step(0, 1, OPCODE_OP,   0, 5, 1, 6, 0, 1, 1, bit_of(5));
    step(0, 1, OPCODE_OP,   0, 5, 1, 6, 0, 1, 0, 32'h0);
    step(0, 1, OPCODE_OP,   0, 6, 6, 7, 0, 1, 0, 32'h0);
    // MUL x7 then ADDI x8,x7: three RAW stall cycles
    step(0, 1, OPCODE_OP,    1, 1, 2, 7, 0, 1, 0, 32'h0);
    step(0, 1, OPCODE_OPIMM, 0, 7, 0, 8, 0, 1, 1, bit_of(7));
    step(0, 1, OPCODE_OPIMM, 0, 7, 0, 8, 0, 1, 1, bit_of(7));
    step(0, 1, OPCODE_OPIMM, 0, 7, 0, 8, 0, 1, 1, bit_of(7));
    step(0, 1, OPCODE_OPIMM, 0, 7, 0, 8, 0, 1, 0, 32'h0);
    // reset while cnt[5]=1: stall forced low, no stall after release
    step(0, 1, OPCODE_LOAD, 0, 1, 0, 5, 0, 1, 0, 32'h0);
    step(0, 1, OPCODE_OP,   0, 5, 0, 6, 0, 0, 0, bit_of(5));
    step(0, 1, OPCODE_OP,   0, 5, 0, 6, 0, 1, 0, 32'h0);
    // MUL x7 then ADDI x7,x0,1: three WAW stall cycles
    step(0, 1, OPCODE_OP,    1, 1, 2, 7, 0, 1, 0, 32'h0);
    step(0, 1, OPCODE_OPIMM, 0, 0, 0, 7, 0, 1, 1, bit_of(7));
    step(0, 1, OPCODE_OPIMM, 0, 0, 0, 7, 0, 1, 1, bit_of(7));
    step(0, 1, OPCODE_OPIMM, 0, 0, 0, 7, 0, 1, 1, bit_of(7));
    step(0, 1, OPCODE_OPIMM, 0, 0, 0, 7, 0, 1, 0, 32'h0, 1, 32'd3, 32'd0, 32'd3);
    // MUL x9 then flush: counters cleared, later use of x9 does not stall
    step(0, 1, OPCODE_OP, 1, 1, 2, 9,  0, 1, 0, 32'h0);
    step(0, 1, OPCODE_OP, 0, 9, 9, 10, 1, 1, 0, bit_of(9));
    step(0, 1, OPCODE_OP, 0, 9, 9, 10, 0, 1, 0, 32'h0);
    // back-to-back LOAD x5: cnt equal to L is not a WAW; reload beats decrement
    step(0, 1, OPCODE_LOAD, 0, 1, 0, 5, 0, 1, 0, 32'h0);
    step(0, 1, OPCODE_LOAD, 0, 1, 0, 5, 0, 1, 0, bit_of(5));
    step(0, 0, 7'h0,        0, 0, 0, 0, 0, 1, 0, bit_of(5));
    step(0, 0, 7'h0,        0, 0, 0, 0, 0, 1, 0, 32'h0);
    // no forwarding: ADD x3 then SUB x4,x3,x3 stalls three cycles
    step(1, 1, OPCODE_OP, 0, 1, 2, 3, 0, 1, 0, 32'h0);
    step(1, 1, OPCODE_OP, 0, 3, 3, 4, 0, 1, 1, bit_of(3));
    step(1, 1, OPCODE_OP, 0, 3, 3, 4, 0, 1, 1, bit_of(3));
    step(1, 1, OPCODE_OP, 0, 3, 3, 4, 0, 1, 1, bit_of(3));
    step(1, 1, OPCODE_OP, 0, 3, 3, 4, 0, 1, 0, 32'h0);
    // LOAD x0 is not tracked, so a following use of x0 does not stall
    step(1, 1, OPCODE_LOAD, 0, 1, 0, 0,  0, 1, 0, bit_of(4));
    step(1, 1, OPCODE_OP,   0, 0, 0, 11, 0, 1, 0, bit_of(4));
    @(posedge clk);
    #1;
    idle_all();
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the combinational ID-stage stall logic of the 5-stage RISCV core.
- Keeps a per-register countdown of cycles until each in-flight result can be consumed. Raises `stall_op` on RAW hazards and on WAW completion-order hazards.
- Handles loads, multi-cycle multiply ops, and cores built with or without forwarding.
- Sits beside the ID stage; the pipeline controller holds IF/ID and bubbles ID/EX while `stall_op` is high.

Parameters:
- NUM_REGS, 32, architectural register count; x0 is never tracked.
- ADDR_W, 5, register address width; must be at least clog2(NUM_REGS).
- FORWARD_EN, 1, 1 = full forwarding network present; 0 = consumers wait for writeback.
- LOAD_LAT, 1, extra cycles before load data is forwardable (FORWARD_EN=1).
- MUL_LAT, 3, extra cycles before a multiply/divide result is forwardable (FORWARD_EN=1).
- WB_DIST, 3, extra cycles added to every latency when FORWARD_EN=0.
- CNT_W, 32, width of the performance counters (optional feature only).

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous reset, active-low.
- id_valid_ip  input  1  ID holds a valid instruction.
- id_instr_opcode_ip  input  7  ID opcode (CORE_PKG encodings).
- id_is_mul_ip  input  1  ID instruction is an M-extension op (OPCODE_OP only).
- id_src1_addr_ip  input  ADDR_W  rs1.
- id_src2_addr_ip  input  ADDR_W  rs2.
- id_dest_addr_ip  input  ADDR_W  rd.
- flush_ip  input  1  branch/jump redirect; kills everything younger than MEM.
- stall_op  output  1  hold ID this cycle.
- busy_vec_op  output  NUM_REGS  bit r = counter r nonzero (debug/forwarding qualifier).

Behaviour:
- State: one counter per register, width clog2(max latency + 1). Counter 0 = value consumable now.
- Source use by opcode:
  - OP, STORE, BRANCH: rs1 and rs2.
  - OPIMM, LOAD, JALR: rs1 only.
  - LUI, AUIPC, JAL: no sources.
  - Any other opcode: no sources, no destination.
- Destination write: OP, OPIMM, LOAD, LUI, AUIPC, JAL, JALR.
- Issue latency L:
  - OP with id_is_mul_ip = MUL_LAT.
  - LOAD = LOAD_LAT.
  - All other writers = 0.
  - When FORWARD_EN=0, add WB_DIST to each.
- RAW: a used source s != 0 with cnt[s] != 0 causes a stall.
- WAW: a writer with rd != 0 and cnt[rd] > L causes a stall.
- stall_op (combinational, same cycle) = id_valid_ip & !flush_ip & reset & (RAW | WAW).
- Issue (at posedge) = id_valid_ip & !stall_op & !flush_ip & writer & rd != 0. On issue, cnt[rd] <= L.
- All other nonzero counters decrement by 1 per cycle. This includes cnt[rd] while ID is stalled.
- Simultaneous issue and decrement on the same register: the issue load wins.
- L=0 issue leaves the counter at 0, so there is no stall on a back-to-back ALU dependency.
- Flush: every counter is cleared at the next edge.
  - Older in-flight ops are already past the hazard window under the core's flush point; MUL_LAT ops flushed from EX are discarded.
  - stall_op is 0 during the flush cycle.
- Reset (reset=0 at posedge): all counters 0. stall_op is forced 0 while reset is low.
- Reset mid-operation discards all pending state; no stall persists after release.
- Latency: stall_op has zero-cycle latency. busy_vec_op reflects registered state, one cycle after issue.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs `stall_cycle_cnt_op`, `raw_stall_cnt_op` and `waw_stall_cnt_op`, each CNT_W wide.
  - The first counts every cycle stall_op=1.
  - The others count stall cycles by cause; RAW takes precedence when both causes are present.
  - All three saturate at all-ones and clear only on reset.
- Not defined: the ports and logic are absent; functional behaviour is identical.

Decomposition:
- CORE_PKG: existing OPCODE_* constants, plus new items:
  - op-class enum {OPC_NONE, OPC_ALU, OPC_LOAD, OPC_MUL}.
  - functions uses_rs1(), uses_rs2() and writes_rd() over the opcode.
- Sub-module hazard_lat_counter: one per register (generate loop for r=1..NUM_REGS-1) with load/decrement/clear ports and a nonzero flag.

Test Plan:
- Default params: LOAD x5 issued at cycle 0, ADD x6,x5,x1 in ID at cycle 1 -> stall_op=1 for cycle 1 only, ADD issues at cycle 2.
- MUL x7 (MUL_LAT=3) then ADDI x8,x7,4 -> stall_op high 3 cycles; busy_vec_op[7] high 3 cycles then low.
- MUL x7 then ADDI x7,x0,1 (no source use) -> WAW stall 3 cycles; with HAZARD_PERF_CNT_EN, waw_stall_cnt_op=3 and raw_stall_cnt_op=0.
- FORWARD_EN=0: ADD x3 then SUB x4,x3,x3 -> 3 stall cycles. LOAD x0 followed by a use of x0 -> no stall.
- MUL x9 issued, flush_ip pulsed the next cycle -> all counters 0, a following use of x9 does not stall.
- Assert reset low for 1 cycle while cnt[5]=1 -> stall_op=0 during reset and a use of x5 after release does not stall.
